// File: rtl/bcd_disp_pkg.sv
// Shared types and constants for the BCD up/down counter with 7-segment display.
// Segment patterns are active-low {a,b,c,d,e,f,g}; the decimal point is handled by the top.
package bcd_disp_pkg;

  typedef logic [3:0] bcd_t;

  // All segments off
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Active-low a..g patterns for decimal digits 0..9
  localparam logic [6:0] SEG_TABLE [0:9] = '{
    7'b0000001,  // 0
    7'b1001111,  // 1
    7'b0010010,  // 2
    7'b0000110,  // 3
    7'b1001100,  // 4
    7'b0100100,  // 5
    7'b0100000,  // 6
    7'b0001111,  // 7
    7'b0000000,  // 8
    7'b0000100   // 9
  };

  // Clamp an out-of-range BCD nibble to 9 so a digit never holds an illegal code
  function automatic bcd_t bcd_sat(input bcd_t d);
    return (d > 4'd9) ? 4'd9 : d;
  endfunction

endpackage

// File: rtl/bcd_updown_counter_disp_seg7.sv
// seg7_decode: combinational BCD digit to active-low a..g pattern.
// Codes above 9 are not valid decimal digits and decode to all segments off.
module seg7_decode
  import bcd_disp_pkg::*;
(
  input  bcd_t       digit,
  output logic [6:0] seg_n
);

  // Table lookup; anything outside 0..9 stays blank
  always_comb begin
    seg_n = SEG_BLANK;
    for (int i = 0; i < 10; i++) begin
      if (digit == 4'(i)) seg_n = SEG_TABLE[i];
    end
  end

endmodule

// File: rtl/bcd_updown_counter_disp.sv
// bcd_updown_counter_disp: N-digit BCD up/down counter with run control, preload,
// wrap pulse, timed buzzer and a multiplexed common-anode 7-segment display driver.
// Optional build macro BCD_DISP_BLANK_LEAD_EN: when defined, leading zero digits
// (every more-significant digit also zero) are blanked; digit 0 is always shown.
module bcd_updown_counter_disp
  import bcd_disp_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int CLK_HZ      = 50_000_000,
  parameter int TICK_HZ     = 1,
  parameter int SCAN_CYCLES = 50_000,
  parameter int BUZZ_TICKS  = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    stop,
  input  logic                    updown,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] load_val,
  output logic [4*NUM_DIGITS-1:0] count_bcd,
  output logic [NUM_DIGITS-1:0]   digit_n,
  output logic [7:0]              seg_n,
  output logic                    tc_pulse,
  output logic                    buzzer
);

  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int PW  = (DIV > 2) ? $clog2(DIV) : 1;
  localparam int SW  = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;
  localparam int IW  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int BW  = $clog2(BUZZ_TICKS + 1);

  logic [PW-1:0]         presc_reg;
  logic                  tick;
  logic                  run_reg;
  logic                  count_step;
  logic                  wrap_evt;
  logic                  tc_reg;
  logic [BW-1:0]         buzz_reg;
  logic [SW-1:0]         scan_cnt_reg;
  logic [IW-1:0]         scan_idx_reg;
  logic [NUM_DIGITS-1:0] digit_n_reg;
  logic [7:0]            seg_n_reg;

  bcd_t                  cur_digit [NUM_DIGITS];
  logic [NUM_DIGITS:0]   up_carry;
  logic [NUM_DIGITS:0]   dn_borrow;
  logic [NUM_DIGITS-1:0] blank_vec;
  bcd_t                  sel_digit;
  logic                  sel_blank;
  logic [6:0]            sel_seg;

  // Free-running prescaler; tick marks its last state and is never disturbed by run/load
  always_ff @(posedge clk) begin
    if (reset) begin
      presc_reg <= '0;
    end else if (presc_reg == PW'(DIV - 1)) begin
      presc_reg <= '0;
    end else begin
      presc_reg <= presc_reg + 1'b1;
    end
  end

  assign tick = (presc_reg == PW'(DIV - 1));

  // Run flag: stop dominates start, otherwise hold
  always_ff @(posedge clk) begin
    if (reset) begin
      run_reg <= 1'b0;
    end else if (stop) begin
      run_reg <= 1'b0;
    end else if (start) begin
      run_reg <= 1'b1;
    end
  end

  assign count_step = tick & run_reg;

  // Ripple carry/borrow chains start with an implicit +1/-1 into digit 0
  assign up_carry[0]  = 1'b1;
  assign dn_borrow[0] = 1'b1;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
      bcd_t digit_reg;
      bcd_t inc_d;
      bcd_t dec_d;
      bcd_t load_d;

      assign up_carry[gi+1]  = up_carry[gi] & (digit_reg == 4'd9);
      assign dn_borrow[gi+1] = dn_borrow[gi] & (digit_reg == 4'd0);

      assign inc_d  = !up_carry[gi]  ? digit_reg :
                      (digit_reg == 4'd9) ? 4'd0 : digit_reg + 4'd1;
      assign dec_d  = !dn_borrow[gi] ? digit_reg :
                      (digit_reg == 4'd0) ? 4'd9 : digit_reg - 4'd1;
      assign load_d = bcd_sat(load_val[4*gi +: 4]);

      // Per-digit register: load beats counting, counting only on a running tick
      always_ff @(posedge clk) begin
        if (reset) begin
          digit_reg <= 4'd0;
        end else if (load) begin
          digit_reg <= load_d;
        end else if (count_step) begin
          digit_reg <= updown ? dec_d : inc_d;
        end
      end

      assign cur_digit[gi]          = digit_reg;
      assign count_bcd[4*gi +: 4]   = digit_reg;
    end
  endgenerate

`ifdef BCD_DISP_BLANK_LEAD_EN
  // lead_zero[i] is set when digit i and every digit above it are zero
  logic [NUM_DIGITS:0] lead_zero;
  assign lead_zero[NUM_DIGITS] = 1'b1;
  generate
    for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_blank
      assign lead_zero[gi] = lead_zero[gi+1] & (cur_digit[gi] == 4'd0);
      if (gi == 0) begin : g_units
        assign blank_vec[gi] = 1'b0;
      end else begin : g_upper
        assign blank_vec[gi] = lead_zero[gi];
      end
    end
  endgenerate
`else
  assign blank_vec = '0;
`endif

  // A wrap is a counting edge where the whole chain carries/borrows out; load suppresses it
  assign wrap_evt = count_step & ~load & (updown ? dn_borrow[NUM_DIGITS] : up_carry[NUM_DIGITS]);

  // Terminal-count pulse in the cycle after the wrapping edge
  always_ff @(posedge clk) begin
    if (reset) begin
      tc_reg <= 1'b0;
    end else begin
      tc_reg <= wrap_evt;
    end
  end

  // Buzzer timer: reload on every wrap (no accumulation), otherwise count down per tick
  always_ff @(posedge clk) begin
    if (reset) begin
      buzz_reg <= '0;
    end else if (wrap_evt) begin
      buzz_reg <= BW'(BUZZ_TICKS);
    end else if (tick && (buzz_reg != '0)) begin
      buzz_reg <= buzz_reg - 1'b1;
    end
  end

  // Scan timer: hold each digit for SCAN_CYCLES clocks, then move to the next one
  always_ff @(posedge clk) begin
    if (reset) begin
      scan_cnt_reg <= '0;
      scan_idx_reg <= '0;
    end else if (scan_cnt_reg == SW'(SCAN_CYCLES - 1)) begin
      scan_cnt_reg <= '0;
      scan_idx_reg <= (scan_idx_reg == IW'(NUM_DIGITS - 1)) ? '0 : scan_idx_reg + 1'b1;
    end else begin
      scan_cnt_reg <= scan_cnt_reg + 1'b1;
    end
  end

  // Select the digit currently being scanned
  always_comb begin
    sel_digit = 4'd0;
    sel_blank = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (scan_idx_reg == IW'(i)) begin
        sel_digit = cur_digit[i];
        sel_blank = blank_vec[i];
      end
    end
  end

  seg7_decode u_seg7_decode (
    .digit (sel_digit),
    .seg_n (sel_seg)
  );

  // Enable and pattern are registered together so a digit never shows its neighbour's code
  always_ff @(posedge clk) begin
    if (reset) begin
      digit_n_reg <= ~NUM_DIGITS'(1);
      seg_n_reg   <= {SEG_TABLE[0], 1'b1};
    end else begin
      digit_n_reg <= ~(NUM_DIGITS'(1) << scan_idx_reg);
      seg_n_reg   <= {(sel_blank ? SEG_BLANK : sel_seg), 1'b1};
    end
  end

  assign digit_n  = digit_n_reg;
  assign seg_n    = seg_n_reg;
  assign tc_pulse = tc_reg;
  assign buzzer   = (buzz_reg != '0);

endmodule
